// File: rtl/arm_pkg.sv
// Shared ARM decode definitions for the ID stage.
//   - Instruction mode encodings (Instruction[27:26])
//   - exe_cmd opcode constants that change decode behaviour
//   - NOP instruction constant (all-zero word used as a bubble)
//   - id_ex_t: packed payload held in the ID/EX pipeline register
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0]  REG_PC    = 4'd15;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  exe_cmd;
    logic        imm;
    logic        s;
    logic [11:0] shift_op;
    logic [23:0] imm24;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic        b;
  } id_ex_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of instructions in flight after ID and flags
// a read-after-write hazard against the sources of the instruction in ID.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears valid bits)
//   push_vld_i        instruction leaving ID this cycle writes a register
//   push_dest_i       its destination register
//   src1_i/src1_use_i first source and whether it is actually read
//   src2_i/src2_use_i second source and whether it is actually read
//   hazard_o          combinational: some in-flight writer targets a used source
module hazard_scoreboard #(
  parameter int HAZ_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld_i,
  input  logic [3:0] push_dest_i,
  input  logic [3:0] src1_i,
  input  logic       src1_use_i,
  input  logic [3:0] src2_i,
  input  logic       src2_use_i,
  output logic       hazard_o
);

  logic [HAZ_DEPTH-1:0] vld_q, vld_d;
  logic [3:0]           dest_q [HAZ_DEPTH];
  logic [3:0]           dest_d [HAZ_DEPTH];

  always_comb begin
    vld_d[0]  = push_vld_i;
    dest_d[0] = push_dest_i;
    for (int i = 1; i < HAZ_DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      dest_d[i] = dest_q[i-1];
    end
  end

  // Only the valid bits need reset; a stale dest behind valid=0 is harmless.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < HAZ_DEPTH; i++) dest_q[i] <= dest_d[i];
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (vld_q[i] && ((src1_use_i && dest_q[i] == src1_i) ||
                       (src2_use_i && dest_q[i] == src2_i)))
        hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/id_hazard_stage.sv
// ARM instruction-decode stage with stall-only RAW hazard handling.
// Decodes the IF/ID instruction, checks it against in-flight writers, drives
// freeze back to fetch and loads the ID/EX register (or a bubble).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   PC_in, Instruction            IF/ID register contents (0 = NOP)
//   Branch_taken                  EX taken branch: flush ID/EX to a bubble
//   freeze                        combinational stall request to fetch
//   PC, Rn, Rd, Rm, exe_cmd, imm, S, shift_op, imm24   ID/EX datapath fields
//   wb_en, mem_r, mem_w, b        ID/EX control bits
//   stall_cnt, flush_cnt          saturating event counters
module id_hazard_stage
  import arm_pkg::*;
#(
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_in,
  input  logic [31:0]      Instruction,
  input  logic             Branch_taken,
  output logic             freeze,
  output logic [31:0]      PC,
  output logic [3:0]       Rn,
  output logic [3:0]       Rd,
  output logic [3:0]       Rm,
  output logic [3:0]       exe_cmd,
  output logic             imm,
  output logic             S,
  output logic [11:0]      shift_op,
  output logic [23:0]      imm24,
  output logic             wb_en,
  output logic             mem_r,
  output logic             mem_w,
  output logic             b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [1:0] mode;
  logic [3:0] cmd;
  logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;
  logic       use1, use2;
  logic [3:0] src2;
  logic       hazard;
  logic       unused_cond;

  assign mode        = Instruction[27:26];
  assign cmd         = Instruction[24:21];
  assign unused_cond = ^Instruction[31:28];

  always_comb begin
    dec_wb = 1'b0;
    dec_mr = 1'b0;
    dec_mw = 1'b0;
    dec_b  = 1'b0;
    dec_s  = Instruction[20];
    use1   = 1'b0;
    use2   = 1'b0;
    src2   = Instruction[3:0];
    if (Instruction == NOP_INSTR || mode == MODE_NOP) begin
      dec_s = 1'b0;
    end else begin
      case (mode)
        MODE_DP: begin
          dec_wb = !(cmd == OP_CMP || cmd == OP_TST);
          use1   = !(cmd == OP_MOV || cmd == OP_MVN);
          use2   = !Instruction[25];
        end
        MODE_MEM: begin
          dec_wb = Instruction[20];
          dec_mr = Instruction[20];
          dec_mw = !Instruction[20];
          use1   = 1'b1;
          // Stores read the data register through the Rd field.
          use2   = !Instruction[20];
          src2   = Instruction[15:12];
        end
        default: dec_b = 1'b1;
      endcase
    end
    // R15 reads come from the PC, never from an in-flight writer.
    if (Instruction[19:16] == REG_PC) use1 = 1'b0;
    if (src2 == REG_PC)               use2 = 1'b0;
  end

  hazard_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (dec_wb && !hazard && !Branch_taken),
    .push_dest_i(Instruction[15:12]),
    .src1_i     (Instruction[19:16]),
    .src1_use_i (use1),
    .src2_i     (src2),
    .src2_use_i (use2),
    .hazard_o   (hazard)
  );

  // A taken branch wins over a stall so fetch can load the target.
  assign freeze = hazard && !Branch_taken;

  id_ex_t           id_ex_q, id_ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    id_ex_d          = '0;
    id_ex_d.pc       = PC_in;
    id_ex_d.rn       = Instruction[19:16];
    id_ex_d.rd       = Instruction[15:12];
    id_ex_d.rm       = Instruction[3:0];
    id_ex_d.exe_cmd  = cmd;
    id_ex_d.imm      = Instruction[25];
    id_ex_d.shift_op = Instruction[11:0];
    id_ex_d.imm24    = Instruction[23:0];
    stall_cnt_d      = stall_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    if (Branch_taken) begin
      id_ex_d     = '0;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (hazard) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      id_ex_d.s     = dec_s;
      id_ex_d.wb_en = dec_wb;
      id_ex_d.mem_r = dec_mr;
      id_ex_d.mem_w = dec_mw;
      id_ex_d.b     = dec_b;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC        = id_ex_q.pc;
  assign Rn        = id_ex_q.rn;
  assign Rd        = id_ex_q.rd;
  assign Rm        = id_ex_q.rm;
  assign exe_cmd   = id_ex_q.exe_cmd;
  assign imm       = id_ex_q.imm;
  assign S         = id_ex_q.s;
  assign shift_op  = id_ex_q.shift_op;
  assign imm24     = id_ex_q.imm24;
  assign wb_en     = id_ex_q.wb_en;
  assign mem_r     = id_ex_q.mem_r;
  assign mem_w     = id_ex_q.mem_w;
  assign b         = id_ex_q.b;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
